// File: rtl/uart_pkg.sv
// Constants and FSM encoding shared by the UART receiver and a future transmitter.
package uart_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    typedef struct packed {
        logic frame_err;
        logic overrun;
    } uart_err_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push while full is accepted only if a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];

    // Storage carries no reset: contents are meaningless while empty.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a small byte FIFO, plus sticky error flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              rd_en,
    input  logic              clr_err,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic              frame_err,
    output logic              overrun,
    output logic [2:0]        dbg_state
);

    localparam int          CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic              r_rx_meta;
    logic              r_rx_s;
    logic [2:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_idx;
    logic [DATA_W-1:0] r_shift;
    uart_err_t         r_err;

    logic w_stop_done;
    logic w_push;
    logic w_pop;
    logic w_ferr_set;
    logic w_ovr_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (!r_rx_s) r_state <= ST_START;
                end
                ST_START: begin
                    // Re-check the start bit at its centre so short glitches are rejected.
                    if (r_cnt == HALF) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= r_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == LAST) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= r_rx_s;
                        r_idx          <= r_idx + 3'd1;
                        if (r_idx == 3'd7) r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_state <= r_rx_s ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    r_cnt <= '0;
                    if (r_rx_s) r_state <= ST_IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_stop_done = (r_state == ST_STOP) && (r_cnt == LAST);
    assign w_push      = w_stop_done && r_rx_s;
    assign w_ferr_set  = w_stop_done && !r_rx_s;
    assign w_pop       = rd_en && !empty;
    assign w_ovr_set   = w_push && full && !w_pop;

    // Error sets win over a coincident clear so no event is ever lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            if (w_ferr_set)   r_err.frame_err <= 1'b1;
            else if (clr_err) r_err.frame_err <= 1'b0;
            if (w_ovr_set)    r_err.overrun   <= 1'b1;
            else if (clr_err) r_err.overrun   <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (r_shift),
        .o_data  (rd_data),
        .o_full  (full),
        .o_empty (empty)
    );

    assign frame_err = r_err.frame_err;
    assign overrun   = r_err.overrun;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a frame table with an expected-byte queue, plus multi-cycle corner sequences.
module tb_uart_rx_fifo;

    localparam int CPB = 16;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic       frame_err;
    logic       overrun;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_push;
        logic       exp_ferr;
    } vec_t;
    vec_t vecs[6];

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .frame_err (frame_err),
        .overrun   (overrun),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves rx at the stop-bit level; the caller decides what follows.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(negedge clk) rx = 1'b0;
        idle(CPB - 1);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk) rx = d[b];
            idle(CPB - 1);
        end
        @(negedge clk) rx = stop;
        idle(CPB - 1);
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        @(posedge clk); #1;
        chk("pop_not_empty", {31'd0, empty}, 32'd0);
        chk(name, {24'd0, rd_data}, {24'd0, exp});
        @(negedge clk) rd_en = 1'b1;
        @(negedge clk) rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        idle(3);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        vecs[0] = '{data: 8'h55, stop: 1'b1, exp_push: 1'b1, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'h00, stop: 1'b1, exp_push: 1'b1, exp_ferr: 1'b0};
        vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_push: 1'b1, exp_ferr: 1'b0};
        vecs[3] = '{data: 8'hA3, stop: 1'b0, exp_push: 1'b0, exp_ferr: 1'b1};
        vecs[4] = '{data: 8'h80, stop: 1'b1, exp_push: 1'b1, exp_ferr: 1'b0};
        vecs[5] = '{data: 8'h01, stop: 1'b1, exp_push: 1'b1, exp_ferr: 1'b0};

        rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        do_reset();
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});

        // Table: one frame per record, checked through the expected queue.
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            rx = 1'b1;
            idle(6);
            @(posedge clk); #1;
            chk("vec_empty", {31'd0, empty}, {31'd0, !vecs[i].exp_push});
            chk("vec_frame_err", {31'd0, frame_err}, {31'd0, vecs[i].exp_ferr});
            chk("vec_overrun", {31'd0, overrun}, 32'd0);
            if (vecs[i].exp_push) exp_q.push_back(vecs[i].data);
            while (exp_q.size() > 0) pop_check("vec_rd_data", exp_q.pop_front());
            @(posedge clk); #1;
            chk("vec_drained", {31'd0, empty}, 32'd1);
            if (vecs[i].exp_ferr) begin
                pulse_clr();
                chk("vec_clr_err", {31'd0, frame_err}, 32'd0);
            end
        end

        // Short low glitch in idle must be rejected.
        @(negedge clk) rx = 1'b0;
        idle(5);
        @(negedge clk) rx = 1'b1;
        idle(20);
        @(posedge clk); #1;
        chk("glitch_empty", {31'd0, empty}, 32'd1);
        chk("glitch_frame_err", {31'd0, frame_err}, 32'd0);
        chk("glitch_state", {29'd0, dbg_state}, {29'd0, S_IDLE});

        // Bad stop bit followed by a long break.
        send_frame(8'hA3, 1'b0);
        idle(100);
        @(posedge clk); #1;
        chk("break_frame_err", {31'd0, frame_err}, 32'd1);
        chk("break_empty", {31'd0, empty}, 32'd1);
        chk("break_state", {29'd0, dbg_state}, {29'd0, S_WAIT_HIGH});
        @(negedge clk) rx = 1'b1;
        idle(10);
        @(posedge clk); #1;
        chk("break_release_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        chk("break_release_empty", {31'd0, empty}, 32'd1);
        pulse_clr();
        chk("break_clr_err", {31'd0, frame_err}, 32'd0);

        // Five frames, no reads: the fifth is dropped.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        idle(6);
        @(posedge clk); #1;
        chk("ovr_full", {31'd0, full}, 32'd1);
        chk("ovr_overrun", {31'd0, overrun}, 32'd1);
        chk("ovr_frame_err", {31'd0, frame_err}, 32'd0);
        for (int i = 1; i <= 4; i++) pop_check("ovr_rd_data", 8'(i));
        @(posedge clk); #1;
        chk("ovr_empty", {31'd0, empty}, 32'd1);
        chk("ovr_not_full", {31'd0, full}, 32'd0);
        pulse_clr();
        chk("ovr_clr", {31'd0, overrun}, 32'd0);

        // Full FIFO with a pop landing exactly on the stop-sample edge.
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1);
        idle(6);
        @(posedge clk); #1;
        chk("sim_full_before", {31'd0, full}, 32'd1);
        seen = 1'b0;
        fork
            send_frame(8'h66, 1'b1);
            begin
                for (int c = 0; c < 400 && !seen; c++) begin
                    @(posedge clk); #1;
                    if (dbg_state == S_STOP) seen = 1'b1;
                end
                if (seen) begin
                    repeat (CPB - 1) @(posedge clk);
                    #1 rd_en = 1'b1;
                    @(posedge clk);
                    #1 rd_en = 1'b0;
                end
            end
        join
        chk("sim_stop_seen", {31'd0, seen}, 32'd1);
        idle(6);
        @(posedge clk); #1;
        chk("sim_overrun", {31'd0, overrun}, 32'd0);
        chk("sim_full_after", {31'd0, full}, 32'd1);
        exp_q = '{8'h12, 8'h13, 8'h14, 8'h66};
        while (exp_q.size() > 0) pop_check("sim_rd_data", exp_q.pop_front());
        @(posedge clk); #1;
        chk("sim_empty", {31'd0, empty}, 32'd1);

        // Reset during bit 4 of a frame, then a clean frame.
        @(negedge clk) rx = 1'b0;
        idle(CPB - 1 + 4 * CPB + 8);
        @(negedge clk) begin rst = 1'b1; rx = 1'b1; end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        chk("midrst_empty", {31'd0, empty}, 32'd1);
        idle(40);
        send_frame(8'h7E, 1'b1);
        idle(6);
        pop_check("midrst_rd_data", 8'h7E);
        @(posedge clk); #1;
        chk("midrst_only_one", {31'd0, empty}, 32'd1);
        chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("midrst_overrun", {31'd0, overrun}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
